// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Control and handshake bundle between the fetch sequencer and
//               the rest of the CPU (control unit, PC, MAR, MDR, memory).
//               The shared data bus is not carried here. It is a multi-drop
//               tristate net owned by the whole datapath, so it is connected
//               as a plain inout next to this interface.
//   slave  : the fetch sequencer (drives strobes, status and instr)
//   master : the surrounding datapath / control unit
//   Signals:
//     start     control unit -> sequencer   fetch request
//     mem_ready memory       -> sequencer   read data available in MDR
//     PC_out    sequencer    -> PC          PC drives the bus
//     PC_in     sequencer    -> PC          PC loads from the bus
//     MAR_in    sequencer    -> MAR         MAR loads from the bus
//     mem_read  sequencer    -> memory      read request
//     MDR_out   sequencer    -> MDR         MDR drives the bus
//     instr     sequencer    -> decode      last fetched instruction
//     busy/done/fault  sequencer -> control unit status
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             mem_ready;
    logic             PC_out;
    logic             PC_in;
    logic             MAR_in;
    logic             mem_read;
    logic             MDR_out;
    logic [WIDTH-1:0] instr;
    logic             busy;
    logic             done;
    logic             fault;

    modport slave (
        input  start,
        input  mem_ready,
        output PC_out,
        output PC_in,
        output MAR_in,
        output mem_read,
        output MDR_out,
        output instr,
        output busy,
        output done,
        output fault
    );

    modport master (
        output start,
        output mem_ready,
        input  PC_out,
        input  PC_in,
        input  MAR_in,
        input  mem_read,
        input  MDR_out,
        input  instr,
        input  busy,
        input  done,
        input  fault
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch sequencer for the 16-bit single-bus CPU.
//               On a start request it routes PC -> MAR over the bus, runs a
//               handshaked memory read, latches the returned word as the
//               current instruction, and writes PC+INC back to the PC.
//               Moore machine: every strobe is decoded from the current state.
// Ports       :
//   clock     in     posedge clock
//   reset     in     synchronous, active-high
//   data_bus  inout  shared CPU bus; driven here only while writing PC+INC
//   ctl       slave  strobes, handshake and status (see fetch_sequencer_if)
// Parameters  :
//   WIDTH     bus / instruction width
//   INC       increment applied to the PC after each fetch
//   TIMEOUT   last wait-counter value tolerated in MEM_REQ before giving up
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int WIDTH   = 16,
    parameter int INC     = 1,
    parameter int TIMEOUT = 255
) (
    input  wire              clock,
    input  wire              reset,
    inout  wire [WIDTH-1:0]  data_bus,
    fetch_sequencer_if.slave ctl
);

    // Wide enough to hold TIMEOUT itself; at least one bit.
    localparam int               CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] PC_STEP   = WIDTH'(INC);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PC_TO_MAR = 3'd1;
    localparam logic [2:0] S_MEM_REQ   = 3'd2;
    localparam logic [2:0] S_MEM_TO_IR = 3'd3;
    localparam logic [2:0] S_PC_INC    = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]       state_q,     state_d;
    logic [CNT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic [WIDTH-1:0] pc_shadow_q, pc_shadow_d;
    logic [WIDTH-1:0] instr_q,     instr_d;
    logic             fault_q,     fault_d;
    logic [WIDTH-1:0] pc_next;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        pc_shadow_d = pc_shadow_q;
        instr_d     = instr_q;
        // fault only lives for the DONE cycle that follows a timeout.
        fault_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctl.start) begin
                    state_d = S_PC_TO_MAR;
                end
            end

            S_PC_TO_MAR: begin
                // PC is on the bus this cycle; keep a copy for the increment
                // so the PC never has to drive the bus a second time.
                pc_shadow_d = data_bus;
                wait_cnt_d  = '0;
                state_d     = S_MEM_REQ;
            end

            S_MEM_REQ: begin
                // Data readiness wins over the timeout on the final cycle.
                if (ctl.mem_ready) begin
                    state_d = S_MEM_TO_IR;
                end else if (wait_cnt_q == CNT_LIMIT) begin
                    state_d = S_DONE;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end

            S_MEM_TO_IR: begin
                instr_d = data_bus;
                state_d = S_PC_INC;
            end

            S_PC_INC: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            pc_shadow_q <= '0;
            instr_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            pc_shadow_q <= pc_shadow_d;
            instr_q     <= instr_d;
            fault_q     <= fault_d;
        end
    end

    // ------------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------------
    // Natural wrap of the WIDTH-bit sum gives the modulo-2^WIDTH increment.
    assign pc_next = pc_shadow_q + PC_STEP;

    assign ctl.PC_out   = (state_q == S_PC_TO_MAR);
    assign ctl.MAR_in   = (state_q == S_PC_TO_MAR);
    assign ctl.mem_read = (state_q == S_MEM_REQ);
    assign ctl.MDR_out  = (state_q == S_MEM_TO_IR);
    assign ctl.PC_in    = (state_q == S_PC_INC);
    assign ctl.busy     = (state_q != S_IDLE);
    assign ctl.done     = (state_q == S_DONE);
    assign ctl.fault    = fault_q;
    assign ctl.instr    = instr_q;

    assign data_bus = (state_q == S_PC_INC) ? pc_next : {WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. Surrounds the DUT
//               with a PC, MAR and MDR model on a shared bus, drives directed
//               fetch scenarios and compares every cycle against a
//               schedule-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int WIDTH = 16;
    localparam int TMO   = 4;

    logic             clock = 1'b0;
    logic             reset;
    wire  [WIDTH-1:0] data_bus;

    fetch_sequencer_if #(.WIDTH(WIDTH)) ifc ();

    fetch_sequencer #(
        .WIDTH   (WIDTH),
        .INC     (1),
        .TIMEOUT (TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .data_bus (data_bus),
        .ctl      (ifc)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------------
    // Datapath around the DUT: PC, MAR, MDR on the shared bus
    // ------------------------------------------------------------------------
    logic [15:0] pc_reg  = 16'h0;
    logic [15:0] mar_reg = 16'h0;
    logic [15:0] pc_preset;
    logic [15:0] mdr;
    logic        pc_load;

    always @(posedge clock) begin
        if (pc_load)         pc_reg <= pc_preset;
        else if (ifc.PC_in)  pc_reg <= data_bus;
        if (ifc.MAR_in)      mar_reg <= data_bus;
    end

    assign data_bus = ifc.PC_out  ? pc_reg : {WIDTH{1'bz}};
    assign data_bus = ifc.MDR_out ? mdr    : {WIDTH{1'bz}};

    // Inputs as seen by the DUT at each rising edge.
    logic        s_reset = 1'b0, s_start = 1'b0, s_ready = 1'b0;
    logic [15:0] s_pc = 16'h0;
    always @(posedge clock) begin
        s_reset <= reset;
        s_start <= ifc.start;
        s_ready <= ifc.mem_ready;
        s_pc    <= pc_reg;
    end

    // ------------------------------------------------------------------------
    // Reference model: a fetch is a timeline measured in cycles since start.
    // Cycle 1 moves PC to MAR, the request runs from cycle 2 up to the cycle
    // mem_ready is seen (or TMO+1 cycles), then IR load, PC write, done.
    // A timeout ends straight into done.
    // ------------------------------------------------------------------------
    initial begin : compare
        int          m_off   = -1;   // cycle number within fetch, -1 idle
        int          m_end   = 0;    // last request cycle, 0 while unknown
        bit          m_fault = 1'b0;
        bit          m_live  = 1'b0;
        logic [15:0] m_pc    = 16'h0;
        logic [15:0] m_instr = 16'h0;
        logic [15:0] m_inc;
        logic [7:0]  exp_s, act_s;
        int          drivers;
        forever begin
            @(negedge clock);
            if (s_reset) begin
                m_off = -1; m_end = 0; m_fault = 1'b0; m_instr = 16'h0; m_live = 1'b1;
            end else if (m_live) begin
                if (m_off < 0) begin
                    if (s_start) begin
                        m_off = 1; m_end = 0; m_fault = 1'b0;
                    end
                end else begin
                    if (m_off == 1) m_pc = s_pc;
                    if (m_off >= 2 && m_end == 0) begin
                        if (s_ready) m_end = m_off;
                        else if (m_off - 2 == TMO) begin
                            m_end = m_off; m_fault = 1'b1;
                        end
                    end
                    if (!m_fault && m_end != 0 && m_off == m_end + 1) m_instr = mdr;
                    if (m_end != 0 && m_off == m_end + (m_fault ? 1 : 3)) m_off = -1;
                    else m_off++;
                end
            end

            // {PC_out, MAR_in, mem_read, MDR_out, PC_in, busy, done, fault}
            exp_s = 8'h00;
            if (m_off >= 1) exp_s[2] = 1'b1;
            if (m_off == 1) exp_s[7:6] = 2'b11;
            if (m_off >= 2 && (m_end == 0 || m_off <= m_end)) exp_s[5] = 1'b1;
            if (m_end != 0 && !m_fault) begin
                if (m_off == m_end + 1) exp_s[4] = 1'b1;
                if (m_off == m_end + 2) exp_s[3] = 1'b1;
                if (m_off == m_end + 3) exp_s[1] = 1'b1;
            end
            if (m_end != 0 && m_fault && m_off == m_end + 1) exp_s[1:0] = 2'b11;

            if (m_live) begin
                act_s = {ifc.PC_out, ifc.MAR_in, ifc.mem_read, ifc.MDR_out,
                         ifc.PC_in, ifc.busy, ifc.done, ifc.fault};
                chk("strobes", {24'h0, act_s}, {24'h0, exp_s});
                chk("instr", {16'h0, ifc.instr}, {16'h0, m_instr});
                if (exp_s[3]) begin
                    m_inc = m_pc + 16'd1;
                    chk("bus_pc_inc", {16'h0, data_bus}, {16'h0, m_inc});
                end
                drivers = int'(ifc.PC_out) + int'(ifc.MDR_out) + int'(ifc.PC_in);
                checks++;
                if (drivers > 1) begin
                    failures++;
                    $display("FAIL bus_drivers actual=%0d required<=1", drivers);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic run_fetch(input logic [15:0] pc, input logic [15:0] word,
                             input int waits, input int ncyc, input logic [31:0] start_mask,
                             output int done_at, output int done_cnt, output int rd_cnt,
                             output int pcin_cnt, output logic fault_seen);
        done_at = -1; done_cnt = 0; rd_cnt = 0; pcin_cnt = 0; fault_seen = 1'b0;
        @(negedge clock);
        pc_preset = pc; pc_load = 1'b1; mdr = word;
        ifc.start = 1'b1; ifc.mem_ready = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            pc_load       = 1'b0;
            ifc.start     = (k < 32) ? start_mask[k] : 1'b0;
            ifc.mem_ready = (waits >= 0) && (k == 2 + waits);
            if (ifc.mem_read) rd_cnt++;
            if (ifc.PC_in)    pcin_cnt++;
            if (ifc.done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at    = k;
                    fault_seen = ifc.fault;
                end
            end
        end
        ifc.start = 1'b0; ifc.mem_ready = 1'b0;
    endtask

    initial begin : stim
        int   d_at, d_cnt, rd, pcin;
        logic flt;
        reset = 1'b1; ifc.start = 1'b0; ifc.mem_ready = 1'b0;
        pc_load = 1'b0; pc_preset = 16'h0; mdr = 16'h0;
        repeat (3) @(negedge clock);
        chk("rst_strobes", {24'h0, ifc.PC_out, ifc.MAR_in, ifc.mem_read, ifc.MDR_out,
                            ifc.PC_in, ifc.busy, ifc.done, ifc.fault}, 32'h0);
        chk("rst_instr", {16'h0, ifc.instr}, 32'h0);
        reset = 1'b0;

        // Basic fetch, zero wait states
        run_fetch(16'h0040, 16'hA5C3, 0, 8, 32'h0, d_at, d_cnt, rd, pcin, flt);
        chk("basic_done_at", d_at, 5);
        chk("basic_done_cnt", d_cnt, 1);
        chk("basic_instr", {16'h0, ifc.instr}, 32'h0000_A5C3);
        chk("basic_pc", {16'h0, pc_reg}, 32'h0000_0041);
        chk("basic_mar", {16'h0, mar_reg}, 32'h0000_0040);
        chk("basic_fault", {31'h0, flt}, 32'h0);
        chk("basic_rd_cycles", rd, 1);

        // PC wrap-around
        run_fetch(16'hFFFF, 16'h7E81, 0, 8, 32'h0, d_at, d_cnt, rd, pcin, flt);
        chk("wrap_done_at", d_at, 5);
        chk("wrap_pc", {16'h0, pc_reg}, 32'h0000_0000);
        chk("wrap_mar", {16'h0, mar_reg}, 32'h0000_FFFF);
        chk("wrap_instr", {16'h0, ifc.instr}, 32'h0000_7E81);

        // Three wait states
        run_fetch(16'h0040, 16'hA5C3, 3, 11, 32'h0, d_at, d_cnt, rd, pcin, flt);
        chk("wait_done_at", d_at, 8);
        chk("wait_rd_cycles", rd, 4);
        chk("wait_instr", {16'h0, ifc.instr}, 32'h0000_A5C3);
        chk("wait_pc", {16'h0, pc_reg}, 32'h0000_0041);
        chk("wait_mar", {16'h0, mar_reg}, 32'h0000_0040);
        chk("wait_fault", {31'h0, flt}, 32'h0);

        // Timeout: mem_ready never arrives
        run_fetch(16'h0100, 16'hDEAD, -1, 10, 32'h0, d_at, d_cnt, rd, pcin, flt);
        chk("tmo_done_at", d_at, TMO + 3);
        chk("tmo_fault", {31'h0, flt}, 32'h1);
        chk("tmo_pc_in_cycles", pcin, 0);
        chk("tmo_rd_cycles", rd, TMO + 1);
        chk("tmo_instr", {16'h0, ifc.instr}, 32'h0000_A5C3);
        chk("tmo_pc", {16'h0, pc_reg}, 32'h0000_0100);
        chk("tmo_idle", {31'h0, ifc.busy}, 32'h0);

        // Reset in the middle of MEM_REQ
        @(negedge clock);
        pc_preset = 16'h0200; pc_load = 1'b1; ifc.start = 1'b1; mdr = 16'hBEEF;
        @(negedge clock);
        pc_load = 1'b0; ifc.start = 1'b0;
        @(negedge clock);
        chk("rmid_in_req", {31'h0, ifc.mem_read}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        chk("rmid_strobes", {24'h0, ifc.PC_out, ifc.MAR_in, ifc.mem_read, ifc.MDR_out,
                             ifc.PC_in, ifc.busy, ifc.done, ifc.fault}, 32'h0);
        chk("rmid_instr", {16'h0, ifc.instr}, 32'h0);
        chk("rmid_pc", {16'h0, pc_reg}, 32'h0000_0200);
        reset = 1'b0;
        run_fetch(16'h0300, 16'h5AA5, 1, 9, 32'h0, d_at, d_cnt, rd, pcin, flt);
        chk("rpost_done_at", d_at, 6);
        chk("rpost_instr", {16'h0, ifc.instr}, 32'h0000_5AA5);
        chk("rpost_pc", {16'h0, pc_reg}, 32'h0000_0301);

        // start pulses in cycles 2 and 5 must not spawn another fetch
        run_fetch(16'h0400, 16'h1357, 0, 14, 32'h0000_0024, d_at, d_cnt, rd, pcin, flt);
        chk("ign_done_cnt", d_cnt, 1);
        chk("ign_done_at", d_at, 5);
        chk("ign_pc_in_cycles", pcin, 1);
        chk("ign_instr", {16'h0, ifc.instr}, 32'h0000_1357);
        chk("ign_pc", {16'h0, pc_reg}, 32'h0000_0401);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the 16-bit single-bus CPU. It sits directly downstream of the program counter and upstream of instruction decode. On a `start` pulse it:

- moves the PC onto the shared data bus and into the memory address register;
- performs a handshaked memory read and latches the returned word as the current instruction;
- writes PC+INC back into the program counter over the bus.

The block owns the fetch-phase control strobes only. The control unit resumes ownership after `done`.

## Interface
Parameters:
- `WIDTH`, 16: data bus and instruction width.
- `INC`, 1: increment added to the PC after each fetch.
- `TIMEOUT`, 255: maximum number of MEM_REQ cycles without `mem_ready` before the fetch is abandoned.

Ports:
- `clock`  in  1: all state changes on posedge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: fetch request from the control unit. Sampled only in IDLE.
- `data_bus`  inout  WIDTH: shared CPU bus. Driven only in PC_INC, otherwise high-Z.
- `PC_out`  out  1: program counter drives the bus.
- `PC_in`  out  1: program counter loads from the bus.
- `MAR_in`  out  1: memory address register loads from the bus.
- `mem_read`  out  1: memory read request.
- `mem_ready`  in  1: memory read data is available in the MDR.
- `MDR_out`  out  1: memory data register drives the bus.
- `instr`  out  WIDTH: last fetched instruction.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at the end of a fetch.
- `fault`  out  1: valid with `done`. High means the memory read timed out.

## Operation
- Moore FSM. All strobes are decoded from the current state only, with no input-to-output combinational paths.
- States and transitions:
  - IDLE: no strobes asserted. Goes to PC_TO_MAR if `start`, otherwise stays in IDLE.
  - PC_TO_MAR: `PC_out`=1, `MAR_in`=1. Captures `data_bus` into `pc_shadow`. Goes to MEM_REQ.
  - MEM_REQ: `mem_read`=1. Clears the wait counter on entry and increments it each cycle.
    - `mem_ready`=1: goes to MEM_TO_IR.
    - Counter reaches TIMEOUT: goes to DONE with `fault` set.
    - Otherwise: stays in MEM_REQ.
  - MEM_TO_IR: `MDR_out`=1. Captures `data_bus` into `instr`. Goes to PC_INC.
  - PC_INC: block drives `data_bus` = `pc_shadow`+INC, truncated to WIDTH. `PC_in`=1. Goes to DONE.
  - DONE: `done`=1, `fault` valid. Goes to IDLE.
- Arithmetic: the increment is modulo 2^WIDTH, so 16'hFFFF+1 = 16'h0000. No carry out.
- On timeout, `instr` and the PC are left unchanged, and PC_INC is skipped.
- `start` outside IDLE is ignored. It is not queued.
- `mem_ready` outside MEM_REQ is ignored.
- Exactly one bus driver per cycle:
  - PC in PC_TO_MAR;
  - MDR in MEM_TO_IR;
  - this block in PC_INC;
  - nobody in IDLE, MEM_REQ and DONE.
- Reset values: state IDLE; all strobes 0; `busy`=0; `done`=0; `fault`=0; `instr`=0; `pc_shadow`=0; wait counter 0; bus high-Z.
- Reset mid-fetch: FSM returns to IDLE on the next edge. All strobes drop in that cycle, with no partial PC write and no `done`.

## Timing
- `start` sampled high at edge 0. States then follow:
  - PC_TO_MAR in cycle 1;
  - MEM_REQ in cycle 2;
  - MEM_TO_IR in cycle 3 if `mem_ready` is high during cycle 2;
  - PC_INC in cycle 4;
  - DONE in cycle 5.
- Minimum fetch latency is 5 cycles from the `start` edge to `done`. Each cycle `mem_ready` is held low adds one cycle.
- `mem_ready` may be high in the first MEM_REQ cycle, giving zero wait states.
- `instr` updates at the edge leaving MEM_TO_IR and is stable from PC_INC onward, including while `done` is high.
- Timeout: `done` and `fault` assert together, TIMEOUT+1 cycles after MEM_REQ entry.
- Earliest next `start` is sampled in the IDLE cycle after DONE. Back-to-back fetches are therefore 6 cycles apart at minimum.

## Test plan
- Basic fetch: PC model holds 16'h0040, memory returns 16'hA5C3 with zero waits, `start` pulsed. Required response:
  - `done` 5 cycles later;
  - `instr`=16'hA5C3;
  - PC reads 16'h0041;
  - MAR captured 16'h0040;
  - `fault`=0.
- Wait states: same setup with `mem_ready` delayed 3 cycles. Required response: `done` at cycle 8, `mem_read` high for exactly 4 cycles, results identical to the basic fetch.
- Wrap-around: PC=16'hFFFF. Required response: PC becomes 16'h0000 after the fetch, no X on the bus.
- Timeout: TIMEOUT=4, `mem_ready` held low. Required response:
  - `done` and `fault` high together;
  - `instr` unchanged;
  - `PC_in` never asserted;
  - FSM back in IDLE.
- Reset mid-operation: assert `reset` during MEM_REQ. Required response:
  - next cycle all strobes 0, `busy`=0, bus high-Z;
  - `instr`=0;
  - no `done` pulse;
  - a subsequent fetch completes normally.
- Ignored requests: pulse `start` in cycles 2 and 5 of a fetch. Required response: exactly one fetch, one `done` pulse, and a bus-contention checker (at most one driver per cycle) passes throughout.
